conv_pass_sequencer: RTL
========================

Name: conv_pass_sequencer

Overview:
Top-level sequencer for the separable Gaussian blur. It runs one conv_row_controller instance twice: pass 1 reads img SRAM and writes buf SRAM transposed, and pass 2 reads buf SRAM and writes img SRAM transposed back. It also arbitrates both SRAMs between the host port and the convolution engine, and latches the job configuration.

Parameters:
MIN_DIM, 6, minimum accepted nrows/ncols; smaller values are rejected
TIMEOUT_CYCLES, 20'd200000, per-pass watchdog limit (used only with CONV_TIMEOUT_EN)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle job request; sampled only in IDLE
nrows  in  8  image rows; latched on accepted start
ncols  in  8  image cols; latched on accepted start
sigma  in  3  kernel select; latched on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job completion
err  out  1  sticky; set on rejected start (or timeout); cleared by next accepted start
conv_rstn  out  1  engine reset/enable (low = held in reset)
conv_nrows  out  8  engine row count for current pass
conv_ncols  out  8  engine col count for current pass
conv_sigma  out  3  latched sigma
conv_transpose  out  1  tied to 1
conv_busy  in  1  engine busy
conv_src_ctrl  in  img_sram_ctrl_t  engine read-side control
conv_dst_ctrl  in  img_sram_ctrl_t  engine write-side control
conv_src_dout  out  8  data returned to engine from the current source SRAM
host_req  in  1  host SRAM access request
host_sel  in  1  0 = img SRAM, 1 = buf SRAM
host_ctrl  in  img_sram_ctrl_t  host control
host_gnt  out  1  host access granted this cycle
host_dout  out  8  data from the selected SRAM
img_ctrl  out  img_sram_ctrl_t  img SRAM control
img_dout  in  8  img SRAM read data
buf_ctrl  out  img_sram_ctrl_t  buf SRAM control
buf_dout  in  8  buf SRAM read data

Behaviour:
- Reset values: state IDLE; busy=0, done=0, err=0, conv_rstn=0; latched config=0; img_ctrl and buf_ctrl all-zero (write_en=0); host_gnt=0.
- States:
  - IDLE: start with nrows>=MIN_DIM and ncols>=MIN_DIM latches config, clears err, sets busy, goes to P1_ARM. start with any dim <MIN_DIM sets err and stays in IDLE.
  - P1_ARM: conv_rstn=0 for exactly 1 cycle; conv_nrows=nrows_q, conv_ncols=ncols_q; then P1_WAIT.
  - P1_WAIT: conv_rstn=1; on conv_busy=1 go to P1_RUN.
  - P1_RUN: on conv_busy falling (1→0) go to P2_ARM.
  - P2_ARM: conv_rstn=0 for 1 cycle; dims swapped, so conv_nrows=ncols_q and conv_ncols=nrows_q; then P2_WAIT.
  - P2_WAIT and P2_RUN: same rules as pass 1; on conv_busy falling go to FINISH.
  - FINISH: conv_rstn=0; done=1 for 1 cycle; busy=0 on the next cycle; return to IDLE.
- conv_rstn is a registered output. The engine is held in reset in IDLE, every ARM state and FINISH.
- Routing is combinational from the registered state:
  - Pass 1 (P1_*): img_ctrl=conv_src_ctrl, buf_ctrl=conv_dst_ctrl, conv_src_dout=img_dout.
  - Pass 2 (P2_*): buf_ctrl=conv_src_ctrl, img_ctrl=conv_dst_ctrl, conv_src_dout=buf_dout.
  - In ARM states both SRAM ctrls are forced write_en=0.
- Host arbitration:
  - host_gnt=host_req only in IDLE; the host always loses to a running job, with no preemption.
  - When granted, host_ctrl drives the SRAM selected by host_sel; the other SRAM ctrl is all-zero.
  - When not granted, host write_en never reaches either SRAM.
  - host_dout=host_sel ? buf_dout : img_dout, always, independent of grant.
- A start that arrives in the same cycle as host_req in IDLE: start wins. host_gnt=0 that cycle and the job begins.
- start while busy is ignored; no err, no effect.
- Asynchronous reset mid-job returns to IDLE immediately with conv_rstn=0 and all SRAM writes disabled. SRAM contents are undefined after such a reset.

Optional Feature:
CONV_TIMEOUT_EN
- Defined: a 20-bit counter clears on entry to each ARM state and increments in WAIT/RUN states. Reaching TIMEOUT_CYCLES sets err and goes to FINISH; done still pulses.
- Undefined: no counter; WAIT/RUN states wait indefinitely.

Test Plan:
- Start with nrows=8, ncols=10 → P1 engine sees conv_nrows=8/conv_ncols=10; P2 sees 10/8. done pulses once, busy drops the next cycle, and the img SRAM holds the 2-D blurred result matching the reference model.
- Start with nrows=5, ncols=10 → err=1, state stays IDLE, conv_rstn stays 0, busy stays 0. A following valid start clears err.
- host_req=1, host_sel=1 write (row 3, col 4, 0xA5) in IDLE → buf SRAM written; reading back gives host_dout=0xA5.
- host_req held high during a job → host_gnt=0 for every busy cycle and no host writes land; host_gnt=1 on the first IDLE cycle after done.
- Assert rstn low during P2_RUN → all outputs at reset values; a subsequent start runs a full job correctly.
- With CONV_TIMEOUT_EN and TIMEOUT_CYCLES=100, engine model holds conv_busy=1 forever → err=1 and done pulses 100 cycles after P1_WAIT entry.

Source files
------------

// File: rtl/conv_pass_sequencer.sv
// Two-pass transposing blur sequencer with host/engine SRAM arbitration.
// Define CONV_TIMEOUT_EN to add a per-pass watchdog that aborts to FINISH.
package conv_pkg;
  typedef struct packed {
    logic       write_en;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] wdata;
  } img_sram_ctrl_t;
endpackage

module conv_pass_sequencer
  import conv_pkg::*;
#(
  parameter int          MIN_DIM        = 6,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd200000
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic [7:0]     nrows,
  input  logic [7:0]     ncols,
  input  logic [2:0]     sigma,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           conv_rstn,
  output logic [7:0]     conv_nrows,
  output logic [7:0]     conv_ncols,
  output logic [2:0]     conv_sigma,
  output logic           conv_transpose,
  input  logic           conv_busy,
  input  img_sram_ctrl_t conv_src_ctrl,
  input  img_sram_ctrl_t conv_dst_ctrl,
  output logic [7:0]     conv_src_dout,
  input  logic           host_req,
  input  logic           host_sel,
  input  img_sram_ctrl_t host_ctrl,
  output logic           host_gnt,
  output logic [7:0]     host_dout,
  output img_sram_ctrl_t img_ctrl,
  input  logic [7:0]     img_dout,
  output img_sram_ctrl_t buf_ctrl,
  input  logic [7:0]     buf_dout
);

  localparam logic [7:0] MIN_D = 8'(MIN_DIM);

  typedef enum logic [2:0] {
    IDLE, P1_ARM, P1_WAIT, P1_RUN,
    P2_ARM, P2_WAIT, P2_RUN, FINISH
  } state_t;

  state_t     state, next;
  logic [7:0] nrows_q, ncols_q;
  logic [2:0] sigma_q;
  logic       dims_ok, accept, reject;
  logic       tmo, err_set;
  logic       idle, p1, p2, arm;

  assign idle    = state == IDLE;
  assign p1      = state inside {P1_ARM, P1_WAIT, P1_RUN};
  assign p2      = state inside {P2_ARM, P2_WAIT, P2_RUN};
  assign arm     = state inside {P1_ARM, P2_ARM};
  assign dims_ok = (nrows >= MIN_D) && (ncols >= MIN_D);
  assign accept  = idle && start && dims_ok;
  assign reject  = idle && start && !dims_ok;

`ifdef CONV_TIMEOUT_EN
  logic [19:0] tmo_cnt;
  logic        active;

  assign active = state inside {P1_WAIT, P1_RUN, P2_WAIT, P2_RUN};
  assign tmo    = active && (tmo_cnt >= TIMEOUT_CYCLES - 20'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       tmo_cnt <= '0;
    else if (arm)    tmo_cnt <= '0;
    else if (active) tmo_cnt <= tmo_cnt + 20'd1;
  end
`else
  assign tmo = 1'b0 && (TIMEOUT_CYCLES != '0);
`endif

  always_comb begin
    next    = state;
    err_set = 1'b0;
    unique case (state)
      IDLE:    if (accept) next = P1_ARM;
      P1_ARM:  next = P1_WAIT;
      P1_WAIT: if (conv_busy) next = P1_RUN;
      P1_RUN:  if (!conv_busy) next = P2_ARM;
      P2_ARM:  next = P2_WAIT;
      P2_WAIT: if (conv_busy) next = P2_RUN;
      P2_RUN:  if (!conv_busy) next = FINISH;
      FINISH:  next = IDLE;
      default: next = IDLE;
    endcase
    if (tmo) begin
      next    = FINISH;
      err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      conv_rstn <= 1'b0;
      nrows_q   <= '0;
      ncols_q   <= '0;
      sigma_q   <= '0;
    end else begin
      state     <= next;
      busy      <= next != IDLE;
      done      <= next == FINISH;
      conv_rstn <= next inside {P1_WAIT, P1_RUN, P2_WAIT, P2_RUN};
      if (accept) begin
        nrows_q <= nrows;
        ncols_q <= ncols;
        sigma_q <= sigma;
        err     <= 1'b0;
      end else if (reject || err_set) begin
        err <= 1'b1;
      end
    end
  end

  assign conv_nrows     = p2 ? ncols_q : nrows_q;
  assign conv_ncols     = p2 ? nrows_q : ncols_q;
  assign conv_sigma     = sigma_q;
  assign conv_transpose = 1'b1;
  assign host_dout      = host_sel ? buf_dout : img_dout;

  // Host only reaches an SRAM when idle, not starting and out of reset.
  always_comb begin
    img_ctrl      = '0;
    buf_ctrl      = '0;
    conv_src_dout = img_dout;
    host_gnt      = 1'b0;
    unique case (1'b1)
      p1: begin
        img_ctrl = conv_src_ctrl;
        buf_ctrl = conv_dst_ctrl;
      end
      p2: begin
        buf_ctrl      = conv_src_ctrl;
        img_ctrl      = conv_dst_ctrl;
        conv_src_dout = buf_dout;
      end
      idle: begin
        host_gnt = rstn && host_req && !start;
        if (host_gnt) begin
          if (host_sel) buf_ctrl = host_ctrl;
          else          img_ctrl = host_ctrl;
        end
      end
      default: ;
    endcase
    if (arm) begin
      img_ctrl.write_en = 1'b0;
      buf_ctrl.write_en = 1'b0;
    end
  end

endmodule
